// File: rtl/mmul_parallel_lane_dispatcher_if.sv
// Stream bundle between the word source, the lane dispatcher and the engine
// operand ports.
//   in_valid_i / in_data_i / in_ready_o       : single input word stream
//   lane_valid_o / lane_data_o / lane_ready_i : one output stream per lane
// The slave modport is the dispatcher's view; master is the source/sink side.
interface mmul_parallel_lane_dispatcher_if #(
    parameter int unsigned N_LANES    = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                                  in_valid_i;
    logic [DATA_WIDTH-1:0]                 in_data_i;
    logic                                  in_ready_o;
    logic [N_LANES-1:0]                    lane_valid_o;
    logic [N_LANES-1:0][DATA_WIDTH-1:0]    lane_data_o;
    logic [N_LANES-1:0]                    lane_ready_i;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  lane_ready_i,
        output in_ready_o,
        output lane_valid_o,
        output lane_data_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        output lane_ready_i,
        input  in_ready_o,
        input  lane_valid_o,
        input  lane_data_o
    );
endinterface

// File: rtl/mmul_parallel_lane_dispatcher.sv
// Round-robin dispatcher: takes a job of len_i words from one input stream and
// deals word k to lane k mod N_LANES, each lane buffered by a 2-entry FIFO.
//   clk_i, rst_i (sync, active high), clear_i (sync flush, same as rst_i)
//   start_i, len_i : job start (sampled in IDLE only) and job length
//   bus            : input stream + per-lane output streams (slave modport)
//   busy_o         : FSM not in IDLE
//   done_o         : one-cycle pulse in the first IDLE cycle after a job
//   cnt_o          : words accepted in the current/last job
module mmul_parallel_lane_dispatcher #(
    parameter int unsigned N_LANES    = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       start_i,
    input  logic [CNT_WIDTH-1:0]       len_i,
    mmul_parallel_lane_dispatcher_if.slave bus,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [CNT_WIDTH-1:0]       cnt_o
);

    localparam int unsigned PTR_W     = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int unsigned LAST_LANE = N_LANES - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e                             state_q, state_d;
    logic [PTR_W-1:0]                   ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]               cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]               len_q, len_d;
    logic [N_LANES-1:0][1:0]            fill_q, fill_d;
    logic [N_LANES-1:0][DATA_WIDTH-1:0] head_q, head_d;
    logic [N_LANES-1:0][DATA_WIDTH-1:0] tail_q, tail_d;
    logic [N_LANES-1:0]                 lane_valid_q, lane_valid_d;
    logic                               in_ready_q, in_ready_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;

    logic                               accept;
    logic [N_LANES-1:0]                 pop;
    logic [N_LANES-1:0]                 push;

    // Handshakes are judged against registered ready/valid only.
    assign accept = bus.in_valid_i && in_ready_q;
    assign pop    = lane_valid_q & bus.lane_ready_i;

    // Next-state, lane FIFO update and registered-output computation.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        fill_d       = fill_q;
        head_d       = head_q;
        tail_d       = tail_q;
        done_d       = 1'b0;
        push         = '0;
        lane_valid_d = '0;

        if (accept) begin
            push[ptr_q] = 1'b1;
        end

        // FIFO head is kept in its own register so lane_data_o needs no mux.
        // A push into a full lane never occurs because in_ready is blocked.
        for (int i = 0; i < int'(N_LANES); i++) begin
            case ({push[i], pop[i]})
                2'b10: begin
                    if (fill_q[i] == 2'd0) begin
                        head_d[i] = bus.in_data_i;
                    end else begin
                        tail_d[i] = bus.in_data_i;
                    end
                    fill_d[i] = fill_q[i] + 2'd1;
                end
                2'b01: begin
                    if (fill_q[i] == 2'd2) begin
                        head_d[i] = tail_q[i];
                    end
                    fill_d[i] = fill_q[i] - 2'd1;
                end
                2'b11: begin
                    if (fill_q[i] == 2'd2) begin
                        head_d[i] = tail_q[i];
                        tail_d[i] = bus.in_data_i;
                    end else begin
                        head_d[i] = bus.in_data_i;
                    end
                end
                default: begin
                end
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        len_d   = len_i;
                        cnt_d   = '0;
                        ptr_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    ptr_d = (ptr_q == PTR_W'(LAST_LANE)) ? '0 : ptr_q + PTR_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Judged after this cycle's pops so the final pop ends DRAIN.
                if (fill_d == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int i = 0; i < int'(N_LANES); i++) begin
            lane_valid_d[i] = (fill_d[i] != 2'd0);
        end
        busy_d     = (state_d != S_IDLE);
        in_ready_d = (state_d == S_RUN) && (fill_d[ptr_d] != 2'd2);
    end

    // State register; rst_i and clear_i both flush everything.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            fill_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            lane_valid_q <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            fill_q       <= fill_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            lane_valid_q <= lane_valid_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.in_ready_o   = in_ready_q;
    assign bus.lane_valid_o = lane_valid_q;
    assign bus.lane_data_o  = head_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign cnt_o            = cnt_q;

endmodule
